gameboard_port_arbiter: RTL
===========================

# gameboard_port_arbiter

Two-requester arbiter and sequencer for the single gameboardinfo memory port of the gameVisuals system. It shares the port between the local game FSM (requester 0) and the remote-shot handler fed by the communication link (requester 1). It serialises their single-word reads and writes, inserts the port's read latency, and returns acknowledge and read data to each requester. It sits between both requesters and the gameboardinfo port in the top level.

## Interface
Parameters:
- READ_LAT, 1, cycles from address presented to valid gameboardinfo_data_out; legal range 0..3
- ADDR_W, 8, board address width
- DATA_W, 32, board word width

Ports:
- clk_clk  in  1  single clock; all logic on rising edge
- reset_reset  in  1  synchronous, active-high reset
- req_i[0..1]  in  1 each  transaction request; held until matching ack
- we_i[0..1]  in  1 each  1 = write, 0 = read; stable while req high
- addr_i[0..1]  in  ADDR_W each  target address; stable while req high
- wdata_i[0..1]  in  DATA_W each  write data; stable while req high
- lock_i[0..1]  in  1 each  keep grant after ack (GB_ARB_LOCK_EN only)
- ack_o[0..1]  out  1 each  one-cycle completion pulse
- rdata_o[0..1]  out  DATA_W each  read result, valid with ack, held until that requester's next read completes
- busy_o  out  1  high in any state other than IDLE
- gameboardinfo_address  out  ADDR_W  port address
- gameboardinfo_data_in  out  DATA_W  port write data
- gameboardinfo_wren  out  1  port write strobe
- gameboardinfo_data_out  in  DATA_W  port read data

## Operation
- FSM states: IDLE, ISSUE, RWAIT, DONE.
- IDLE: when any req_i is high, pick the winner, latch its we/addr/wdata into the port registers, and go to ISSUE.
- ISSUE: address and data drive the port.
  - Write: wren = 1 for exactly this cycle, then DONE.
  - Read with READ_LAT = 0: capture data_out, then DONE.
  - Read with READ_LAT > 0: go to RWAIT.
- RWAIT: count READ_LAT cycles. In the final cycle, capture gameboardinfo_data_out into the winner's rdata_o, then DONE.
- DONE: ack_o[winner] = 1, update last_grant, then IDLE. The acked requester's req is ignored in DONE.
- Arbitration is round-robin:
  - Single request: that requester wins.
  - Simultaneous requests: the requester that is not last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Address and data outputs hold their last value outside ISSUE/RWAIT. wren is 0 in every state except ISSUE-write.
- A requester may change we/addr/wdata only after ack.
- Reset values: all ack_o 0, all rdata_o 0, busy_o 0, address 0, data_in 0, wren 0, state IDLE, last_grant 1.
- Reset mid-transaction: FSM returns to IDLE at the next edge, wren drops, and the pending transaction is discarded with no ack.

## Timing
- Request first seen high in IDLE at cycle T.
  - Write: wren high in T+1, ack in T+2.
  - Read: address presented in T+1, data sampled in T+1+READ_LAT, ack and rdata valid in T+2+READ_LAT.
- Minimum spacing between grants is 3 cycles for writes (IDLE, ISSUE, DONE) and 3+READ_LAT cycles for reads.
- A request asserted while busy waits. The earliest it can be granted is the IDLE cycle after DONE.

## Configuration
- GB_ARB_LOCK_EN defined:
  - If the winner's lock_i is high in DONE, the other requester is masked in subsequent IDLE cycles.
  - The mask is released in any IDLE cycle where the locked requester's lock_i is low.
  - This provides an atomic read-modify-write of a board cell.
  - last_grant still updates normally.
- GB_ARB_LOCK_EN undefined: lock_i ports exist but are ignored; pure round-robin.

## Test plan
- Write from requester 0 only (addr 0x12, data 0xDEADBEEF, at T) -> wren=1 with address 0x12, data_in 0xDEADBEEF in T+1 only; ack_o[0] in T+2.
- Read from requester 1, READ_LAT=2, model returns 0x0000A5A5 -> ack_o[1] and rdata_o[1]=0x0000A5A5 in T+4; rdata_o[0] unchanged.
- Both requesters request in the same cycle after reset, then both re-request continuously -> grants alternate 0,1,0,1; no ack ever overlaps.
- Reset asserted during RWAIT of a read -> next cycle wren 0, busy_o 0, no ack pulse; a following write completes normally with ack at T+2.
- GB_ARB_LOCK_EN, requester 0 holds lock across a read then a write to 0x30 while requester 1 requests throughout -> requester 0 gets both transactions back-to-back; requester 1 is granted only after lock_i[0] drops. Without the macro -> grants alternate.

Source files
------------

// File: rtl/gameboard_port_arbiter_if.sv
// Requester-side bundle for gameboard_port_arbiter.
//
// Each packed vector or array has index 0 for the local game FSM and
// index 1 for the remote-shot handler.
//   req_i   : transaction request, held high until the matching ack
//   we_i    : 1 = write, 0 = read
//   addr_i  : board address
//   wdata_i : write data
//   lock_i  : keep the grant after ack (used only in lock builds)
//   ack_o   : one-cycle completion pulse
//   rdata_o : read result, valid with ack, held until the next read
//             completes for that requester
//
// Handshake: a requester raises req_i[r] with we/addr/wdata stable and keeps
// all of them unchanged until it sees ack_o[r] = 1. That ack cycle completes
// the transaction. The requester may then present a new transaction at once,
// keeping req_i high, or drop req_i. The arbiter ignores req_i[r] during the
// ack cycle.
interface gameboard_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [1:0]             req_i;
  logic [1:0]             we_i;
  logic [1:0][ADDR_W-1:0] addr_i;
  logic [1:0][DATA_W-1:0] wdata_i;
  logic [1:0]             lock_i;
  logic [1:0]             ack_o;
  logic [1:0][DATA_W-1:0] rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, lock_i,
    input  ack_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, lock_i,
    output ack_o, rdata_o
  );
endinterface

// File: rtl/gameboard_port_arbiter.sv
// gameboard_port_arbiter: shares the single gameboardinfo memory port between
// the local game FSM (requester 0) and the remote-shot handler (requester 1).
// It serialises single-word reads and writes, waits out the port read latency
// and returns ack and read data to the winning requester.
//
// Ports:
//   clk_clk, reset_reset   : clock and synchronous active-high reset
//   req_if (slave)         : requester bundle (req/we/addr/wdata/lock/ack/rdata)
//   busy_o                 : high whenever the FSM is not in IDLE
//   gameboardinfo_address  : port address, held between transactions
//   gameboardinfo_data_in  : port write data, held between transactions
//   gameboardinfo_wren     : port write strobe, high only in ISSUE of a write
//   gameboardinfo_data_out : port read data, valid READ_LAT cycles after address
//   dbg_state              : current FSM state (IDLE=0, ISSUE=1, RWAIT=2, DONE=3)
//
// Optional feature: define GB_ARB_LOCK_EN to let a winner that holds lock_i
// through its ack keep the port. The other requester stays masked until the
// lock holder drops lock_i in an IDLE cycle.
module gameboard_port_arbiter #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  gameboard_port_arbiter_if.slave req_if,
  output logic                  busy_o,
  output logic [ADDR_W-1:0]     gameboardinfo_address,
  output logic [DATA_W-1:0]     gameboardinfo_data_in,
  output logic                  gameboardinfo_wren,
  input  logic [DATA_W-1:0]     gameboardinfo_data_out,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Final RWAIT count value; the capture happens in the cycle it is reached.
  localparam logic [1:0] LAT_LAST = 2'((READ_LAT > 0) ? READ_LAT - 1 : 0);

  state_t                 state_q, state_d;
  logic                   winner_q;
  logic                   last_grant_q;
  logic                   we_q;
  logic [1:0]             lat_cnt_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [1:0][DATA_W-1:0] rdata_q;
  logic [1:0]             mask;
  logic [1:0]             req_eff;
  logic                   grant_idx;
  logic                   capture;

`ifdef GB_ARB_LOCK_EN
  logic lock_act_q;
  logic lock_own_q;

  // While the lock holder keeps lock_i high, only it may be granted.
  always_comb begin
    mask = 2'b11;
    if (lock_act_q && req_if.lock_i[lock_own_q]) begin
      mask = lock_own_q ? 2'b10 : 2'b01;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_if.lock_i;
  assign mask        = 2'b11;
`endif

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    req_eff   = req_if.req_i & mask;
    // Tie goes to the requester that did not win last time.
    grant_idx = (req_eff == 2'b11) ? ~last_grant_q : req_eff[1];
    case (state_q)
      IDLE: begin
        if (req_eff != 2'b00) state_d = ISSUE;
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else if (READ_LAT == 0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          state_d = RWAIT;
        end
      end
      RWAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          capture = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q      <= IDLE;
      winner_q     <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      lat_cnt_q    <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
`ifdef GB_ARB_LOCK_EN
      lock_act_q   <= 1'b0;
      lock_own_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_eff != 2'b00) begin
        winner_q <= grant_idx;
        we_q     <= req_if.we_i[grant_idx];
        addr_q   <= req_if.addr_i[grant_idx];
        wdata_q  <= req_if.wdata_i[grant_idx];
      end
      if (state_q == ISSUE) begin
        lat_cnt_q <= 2'd0;
      end else if (state_q == RWAIT) begin
        lat_cnt_q <= lat_cnt_q + 2'd1;
      end
      if (capture) rdata_q[winner_q] <= gameboardinfo_data_out;
      if (state_q == DONE) last_grant_q <= winner_q;
`ifdef GB_ARB_LOCK_EN
      if (state_q == DONE) begin
        lock_act_q <= req_if.lock_i[winner_q];
        lock_own_q <= winner_q;
      end else if (state_q == IDLE && lock_act_q && !req_if.lock_i[lock_own_q]) begin
        lock_act_q <= 1'b0;
      end
`endif
    end
  end

  assign req_if.ack_o          = (state_q == DONE) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign req_if.rdata_o        = rdata_q;
  assign busy_o                = (state_q != IDLE);
  assign gameboardinfo_address = addr_q;
  assign gameboardinfo_data_in = wdata_q;
  assign gameboardinfo_wren    = (state_q == ISSUE) && we_q;
  assign dbg_state             = state_q;

endmodule
